// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty flags and registered read data
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_data_out;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty    = (r_wptr == r_rptr);
  assign full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_wr_ok  = w_en && !full;
  assign w_rd_ok  = r_en && !empty;
  assign data_out = r_data_out;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr[AW-1:0]] <= data_in;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_ok) begin
        r_data_out <= r_mem[r_rptr[AW-1:0]];
        r_rptr     <= r_rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_cmp;
  int n_bad;

  sync_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs at a falling edge, pass one rising edge, return at the next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = 8'h00;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = 8'h00;
    #2;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_dout", {24'b0, data_out}, 32'h00);
    @(negedge clk);
    rst_n = 1'b0;

    // underflow from reset
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("uf_empty", {31'b0, empty}, 32'd1);
      check("uf_dout", {24'b0, data_out}, 32'h00);
    end
    cycle(1'b1, 1'b0, 8'hA5);
    check("a5_empty", {31'b0, empty}, 32'd0);
    cycle(1'b0, 1'b1, 8'h00);
    check("a5_dout", {24'b0, data_out}, 32'hA5);
    check("a5_empty2", {31'b0, empty}, 32'd1);

    // fill to full, drop overflow, drain
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 8'(i + 1));
      check("fill_full", {31'b0, full}, (i == 7) ? 32'd1 : 32'd0);
      check("fill_empty", {31'b0, empty}, 32'd0);
    end
    cycle(1'b1, 1'b0, 8'hFF);
    check("ovf_full", {31'b0, full}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("drain_dout", {24'b0, data_out}, 32'(i + 1));
      check("drain_full", {31'b0, full}, 32'd0);
      check("drain_empty", {31'b0, empty}, (i == 7) ? 32'd1 : 32'd0);
    end

    // simultaneous read/write at partial occupancy
    cycle(1'b1, 1'b0, 8'h10);
    cycle(1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h20 + i));
      check("rw_dout", {24'b0, data_out}, (i < 2) ? 32'(8'h10 + i) : 32'(8'h20 + i - 2));
      check("rw_full", {31'b0, full}, 32'd0);
      check("rw_empty", {31'b0, empty}, 32'd0);
    end
    cycle(1'b0, 1'b1, 8'h00);
    check("rw_tail0", {24'b0, data_out}, 32'h24);
    cycle(1'b0, 1'b1, 8'h00);
    check("rw_tail1", {24'b0, data_out}, 32'h25);
    check("rw_tail_empty", {31'b0, empty}, 32'd1);

    // full plus simultaneous: write dropped, oldest read
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
    check("fs_pre_full", {31'b0, full}, 32'd1);
    cycle(1'b1, 1'b1, 8'hEE);
    check("fs_dout", {24'b0, data_out}, 32'h30);
    check("fs_full", {31'b0, full}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("fs_drain", {24'b0, data_out}, 32'(8'h30 + i));
    end
    check("fs_empty", {31'b0, empty}, 32'd1);
    cycle(1'b0, 1'b1, 8'h00);
    check("fs_no_ee", {24'b0, data_out}, 32'h37);

    // wrap-around with write/read pairs
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h40 + i));
      check("wr_empty", {31'b0, empty}, 32'd0);
      check("wr_full", {31'b0, full}, 32'd0);
      cycle(1'b0, 1'b1, 8'h00);
      check("wr_dout", {24'b0, data_out}, 32'(8'h40 + i));
      check("wr_empty2", {31'b0, empty}, 32'd1);
    end

    // asynchronous reset during traffic
    cycle(1'b1, 1'b0, 8'h77);
    cycle(1'b1, 1'b0, 8'h78);
    cycle(1'b1, 1'b1, 8'h79);
    check("mr_dout_pre", {24'b0, data_out}, 32'h77);
    w_en    = 1'b1;
    r_en    = 1'b1;
    data_in = 8'h7A;
    #2;
    rst_n = 1'b1;
    #1;
    check("mr_empty", {31'b0, empty}, 32'd1);
    check("mr_full", {31'b0, full}, 32'd0);
    check("mr_dout", {24'b0, data_out}, 32'h00);
    @(negedge clk);
    w_en  = 1'b0;
    r_en  = 1'b0;
    rst_n = 1'b0;
    cycle(1'b0, 1'b1, 8'h00);
    check("mr_rd_empty", {31'b0, empty}, 32'd1);
    check("mr_rd_dout", {24'b0, data_out}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer with parameterizable depth and data width. It provides `full`/`empty` status and write/read enables. Overflow and underflow attempts are ignored. It is the storage element exercised by the layered FIFO testbench and sits between a producer and consumer in the same clock domain.

## Interface
- `DEPTH`, default 8: number of storage entries; must be a power of two, ≥ 2.
- `WIDTH`, default 8: data word width in bits.
- Parameter order in instantiation: `DEPTH`, then `WIDTH`.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-high reset (asserted when 1); clears pointers and `data_out` immediately.
- `w_en`  in  1  write request for the current cycle.
- `r_en`  in  1  read request for the current cycle.
- `data_in`  in  WIDTH  word written when a write is accepted.
- `data_out`  out  WIDTH  registered read data.
- `full`  out  1  FIFO holds DEPTH words.
- `empty`  out  1  FIFO holds 0 words.

## Operation
- Storage: array of DEPTH × WIDTH registers.
- Pointers: write pointer `wptr` and read pointer `rptr`, each log2(DEPTH)+1 bits. The low bits index the array; the MSB is a wrap bit.
- `empty` = (`wptr` == `rptr`).
- `full` = low bits equal AND MSBs differ.
- Both flags are combinational from the pointers.
- Write accepted iff `w_en` && !`full`:
  - `mem[wptr low]` <= `data_in`
  - `wptr` <= `wptr` + 1
- Read accepted iff `r_en` && !`empty`:
  - `data_out` <= `mem[rptr low]`
  - `rptr` <= `rptr` + 1
- Rejected write (full) or rejected read (empty): no state change, and `data_out` holds its value.
- Simultaneous `w_en` and `r_en`:
  - Neither full nor empty: both accepted; occupancy unchanged.
  - Full: only the read is accepted. The write is dropped, not merged.
  - Empty: only the write is accepted. The read returns nothing, and `data_out` holds.
- Pointer increment wraps modulo 2×DEPTH; the array index wraps modulo DEPTH.
- `data_out` holds the last read word until the next accepted read.
- Reset (any time, including mid-operation):
  - `wptr` = `rptr` = 0 and `data_out` = 0, applied asynchronously.
  - Memory contents need not be cleared; they are unreachable after reset.
  - After reset: `empty` = 1, `full` = 0.
- Release of reset takes effect at the next rising edge. Bench drives `rst_n` high 0–10 ns, low afterward (active-high).

## Timing
- Write latency:
  - Word written at edge N is readable by a read request at edge N+1.
  - `empty` deasserts after edge N.
- Read latency: `data_out` updates at the edge where the read is accepted (one-cycle registered read). Data is valid from that edge until the next accepted read.
- Flag timing: `full`/`empty` reflect occupancy after each edge, with no extra cycle delay.
- Throughput: one write and one read per cycle, sustained.
- Inputs are sampled at the rising edge and must be stable around it. The bench drives them on the falling edge (10 ns period).

## Test plan
- Reset:
  - Assert `rst_n` (=1) during traffic.
  - Required: `empty`=1, `full`=0, `data_out`=0 immediately (asynchronously).
  - A read afterward is ignored.
- Fill to full:
  - 8 writes of 0x01..0x08 with `r_en`=0.
  - Required: `full`=1 after the 8th edge, `empty`=0.
  - A 9th write of 0xFF is dropped; 8 subsequent reads return 0x01..0x08.
- Empty flag / underflow:
  - From reset, `r_en`=1 for 3 cycles.
  - Required: `empty` stays 1 and `data_out` stays 0x00.
  - Then write 0xA5 once: `empty`=0 next cycle; one read gives `data_out`=0xA5 and `empty`=1.
- Simultaneous R/W:
  - Preload 0x10, 0x11; then 6 cycles with both `w_en` and `r_en`, writing 0x20..0x25.
  - Required: reads return 0x10, 0x11, 0x20, 0x21, 0x22, 0x23; flags never toggle.
- Full + simultaneous:
  - With FIFO full, assert `w_en` and `r_en` with `data_in`=0xEE.
  - Required: oldest word is read, `full`=0, 0xEE is not stored.
- Wrap-around:
  - 20 write/read pairs of incrementing data across pointer wrap.
  - Required: output order is exactly the input order; no spurious `full`/`empty`.
